// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a first-word-fall-through byte FIFO and sends each
// byte as a UART frame (start, 8 data bits LSB first, stop) on a single line.
// Optional even-parity bit between the data and stop bits is enabled by
// defining the macro FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       empty,
    input  logic [7:0] r_data,
    output logic       rd,
    output logic       tx,
    output logic       busy
);

    // Counter just wide enough for CLKS_PER_BIT-1 (at least one bit).
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t           state_r;
    logic [CNT_W-1:0] baud_cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             tx_r;
    logic             rd_s;
    logic             terminal_s;
`ifdef FIFO_UART_TX_PARITY_EN
    logic             parity_r;
`endif

    // Pop strobe and end-of-bit-period detect; reset blocks a pop so the
    // FIFO is never drained while the block is held in reset.
    always_comb begin
        rd_s       = 1'b0;
        terminal_s = 1'b0;
        if (!reset && (state_r == IDLE) && en && !empty) begin
            rd_s = 1'b1;
        end else begin
            rd_s = 1'b0;
        end
        if (baud_cnt_r == CNT_MAX) begin
            terminal_s = 1'b1;
        end else begin
            terminal_s = 1'b0;
        end
    end

    // Frame sequencer: captures the popped byte, times each bit and drives
    // the line from a register so it never glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            tx_r       <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    baud_cnt_r <= '0;
                    bit_idx_r  <= 3'd0;
                    if (rd_s) begin
                        shift_r <= r_data;
`ifdef FIFO_UART_TX_PARITY_EN
                        parity_r <= even_parity(r_data);
`endif
                        tx_r    <= 1'b0;
                        state_r <= START;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                START: begin
                    if (terminal_s) begin
                        baud_cnt_r <= '0;
                        tx_r       <= shift_r[0];
                        state_r    <= DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (terminal_s) begin
                        baud_cnt_r <= '0;
                        shift_r    <= {1'b0, shift_r[7:1]};
                        bit_idx_r  <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            tx_r    <= parity_r;
                            state_r <= PARITY;
`else
                            tx_r    <= 1'b1;
                            state_r <= STOP;
`endif
                        end else begin
                            // Next data bit is bit 1 of the pre-shift value.
                            tx_r <= shift_r[1];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_ONE;
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    if (terminal_s) begin
                        baud_cnt_r <= '0;
                        tx_r       <= 1'b1;
                        state_r    <= STOP;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_ONE;
                    end
                end
`endif
                STOP: begin
                    if (terminal_s) begin
                        baud_cnt_r <= '0;
                        tx_r       <= 1'b1;
                        state_r    <= IDLE;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    baud_cnt_r <= '0;
                    bit_idx_r  <= 3'd0;
                    tx_r       <= 1'b1;
                end
            endcase
        end
    end

    assign rd   = rd_s;
    assign tx   = tx_r;
    assign busy = (state_r != IDLE) || rd_s;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed self-checking bench for fifo_uart_tx with CLKS_PER_BIT = 4.
// A small queue models the FIFO read side (first-word-fall-through).
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int SPACING = FRAME_BITS * CPB + 1;

    logic       clk;
    logic       reset;
    logic       en;
    logic       empty;
    logic [7:0] r_data;
    logic       rd;
    logic       tx;
    logic       busy;

    logic [7:0] fifo_q[$];
    int         vectors;
    int         miscompares;
    int         cyc;
    int         pop_cyc;
    logic       s_rd;
    logic       s_tx;
    logic       s_busy;
`ifdef FIFO_UART_TX_PARITY_EN
    logic       par_seen;
`endif

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .empty  (empty),
        .r_data (r_data),
        .rd     (rd),
        .tx     (tx),
        .busy   (busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "time limit reached");
    end

    task automatic drive_fifo();
        empty = (fifo_q.size() == 0);
        if (fifo_q.size() == 0) r_data = 8'h00;
        else r_data = fifo_q[0];
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        drive_fifo();
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s at cycle %0d: observed %0b, expected %0b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s at cycle %0d: observed %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // One clock: sample outputs mid-cycle, then apply the FIFO pop after the edge.
    task automatic tick();
        @(negedge clk);
        cyc    = cyc + 1;
        s_rd   = rd;
        s_tx   = tx;
        s_busy = busy;
        @(posedge clk);
        #1;
        if (s_rd && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    // One cycle in which a pop is required.
    task automatic expect_pop(input string tag);
        tick();
        check_bit({tag, "_rd"}, s_rd, 1'b1);
        check_bit({tag, "_busy"}, s_busy, 1'b1);
        check_bit({tag, "_tx"}, s_tx, 1'b1);
    endtask

    // One cycle in which the block must be idle.
    task automatic expect_idle(input string tag);
        tick();
        check_bit({tag, "_rd"}, s_rd, 1'b0);
        check_bit({tag, "_busy"}, s_busy, 1'b0);
        check_bit({tag, "_tx"}, s_tx, 1'b1);
    endtask

    // Checks every cycle of a frame for byte b following its pop cycle.
    // drop_en_at: frame cycle after which en is lowered (-1 = never).
    // abort_at: number of frame cycles to check before returning (-1 = all).
    task automatic check_frame(input string tag, input logic [7:0] b,
                               input int drop_en_at, input int abort_at);
        logic eb;
        int   k;
        k = 0;
        for (int j = 0; j < FRAME_BITS; j++) begin
            if (j == 0) eb = 1'b0;
            else if (j <= 8) eb = b[j-1];
            else if (j == FRAME_BITS - 1) eb = 1'b1;
            else eb = ^b;
            for (int c = 0; c < CPB; c++) begin
                if (k == abort_at) return;
                tick();
                check_bit({tag, "_tx"}, s_tx, eb);
                check_bit({tag, "_busy"}, s_busy, 1'b1);
                check_bit({tag, "_rd"}, s_rd, 1'b0);
`ifdef FIFO_UART_TX_PARITY_EN
                if ((j == 9) && (c == 0)) par_seen = s_tx;
`endif
                if (k == drop_en_at) en = 1'b0;
                k = k + 1;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        pop_cyc     = 0;
        reset       = 1'b1;
        en          = 1'b1;
        drive_fifo();

        // Reset held with data available: no pop, line high, not busy.
        push(8'hA5);
        repeat (3) begin
            tick();
            check_bit("rst_tx", s_tx, 1'b1);
            check_bit("rst_rd", s_rd, 1'b0);
            check_bit("rst_busy", s_busy, 1'b0);
        end
        reset = 1'b0;

        // 0xA5: 0 | 1,0,1,0,0,1,0,1 | 1, then idle.
        expect_pop("a5_pop");
        check_frame("a5", 8'hA5, -1, -1);
`ifdef FIFO_UART_TX_PARITY_EN
        check_bit("a5_parity", par_seen, 1'b0);
`endif
        expect_idle("a5_done");
        expect_idle("a5_idle2");

        // 0x07: odd number of ones.
        push(8'h07);
        expect_pop("07_pop");
        check_frame("07", 8'h07, -1, -1);
`ifdef FIFO_UART_TX_PARITY_EN
        check_bit("07_parity", par_seen, 1'b1);
`endif
        expect_idle("07_done");

        // Back-to-back frames from a preloaded FIFO.
        push(8'h55);
        push(8'h0F);
        push(8'hFF);
        expect_pop("b2b_pop0");
        pop_cyc = cyc;
        check_frame("b2b_55", 8'h55, -1, -1);
        expect_pop("b2b_pop1");
        check_int("b2b_spacing1", cyc - pop_cyc, SPACING);
        pop_cyc = cyc;
        check_frame("b2b_0f", 8'h0F, -1, -1);
        expect_pop("b2b_pop2");
        check_int("b2b_spacing2", cyc - pop_cyc, SPACING);
        check_frame("b2b_ff", 8'hFF, -1, -1);
        expect_idle("b2b_done");

        // en dropped during data bit 2 of 0x3C; frame completes, then hold.
        push(8'h3C);
        push(8'h99);
        expect_pop("en_pop");
        check_frame("en_3c", 8'h3C, 13, -1);
        repeat (5) expect_idle("en_hold");
        en = 1'b1;
        expect_pop("en_resume_pop");
        check_frame("en_99", 8'h99, -1, -1);
        expect_idle("en_done");

        // Reset during data bit 4 of 0x81; 0x81 is lost, 0x42 follows.
        push(8'h81);
        push(8'h42);
        expect_pop("mid_pop");
        check_frame("mid_81", 8'h81, -1, 21);
        reset = 1'b1;
        tick();
        check_bit("mid_rst_tx", s_tx, 1'b1);
        check_bit("mid_rst_rd", s_rd, 1'b0);
        check_bit("mid_rst_busy", s_busy, 1'b0);
        reset = 1'b0;
        expect_pop("mid_next_pop");
        check_frame("mid_42", 8'h42, -1, -1);
        expect_idle("mid_done");
        check_int("fifo_drained", fifo_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
